// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared constants and helpers for the N:1 stream multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Channel-selection modes
    localparam int MODE_SEL = 0;  // external select input picks the channel
    localparam int MODE_RR  = 1;  // round-robin arbitration among valid channels

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin candidate search. Returns the first requesting
//                channel at or above ptr, wrapping modulo NCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any_req
);

    localparam logic [SELW:0] c_nch = (SELW + 1)'(NCH);

    logic [NCH-1:0]  w_rot;
    logic [SELW-1:0] w_off;
    logic [SELW:0]   w_sum;

    // Rotate so bit 0 corresponds to channel ptr; the doubled vector handles wrap
    assign w_rot   = NCH'({req, req} >> ptr);
    assign any_req = |req;

    // Lowest set bit of the rotated request is the distance from ptr
    always_comb begin
        w_off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SELW'(i);
            end
        end
    end

    // Map the distance back to an absolute channel index, wrapping below NCH
    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= c_nch) begin
            w_sum = w_sum - c_nch;
        end
        grant = w_sum[SELW-1:0];
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_n1_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n1_stream
//  Description : N:1 valid/ready stream multiplexer with a single registered
//                output stage. Channel chosen by external select (MODE 0) or
//                round-robin arbitration (MODE 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n1_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_id
);

    localparam logic [SELW:0] c_nch = (SELW + 1)'(NCH);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_id;

    logic             w_load_en;
    logic [SELW-1:0]  w_cand;
    logic             w_cand_ok;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_cand_valid;
    logic [NCH-1:0]   w_ready;
    logic             w_xfer;

    // The output register can take a word when empty or being drained
    assign w_load_en = !r_out_valid | out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] r_ptr;
            logic [SELW-1:0] w_grant;
            logic            w_any;
            logic            w_unused_sel;

            // sel has no role when arbitrating
            assign w_unused_sel = ^sel;

            rr_pick #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_rr_pick (
                .req     (in_valid),
                .ptr     (r_ptr),
                .grant   (w_grant),
                .any_req (w_any)
            );

            // With nobody requesting there is no candidate, so no ready is offered
            assign w_cand    = w_grant;
            assign w_cand_ok = w_any;

            // Priority pointer moves just past the channel that was served
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (w_cand == SELW'(NCH - 1)) ? '0 : w_cand + 1'b1;
                end
            end
        end else begin : g_sel
            // Out-of-range select (non-power-of-two NCH) yields no candidate
            assign w_cand    = sel;
            assign w_cand_ok = ({1'b0, sel} < c_nch);
        end
    endgenerate

    // Candidate data/valid mux and one-hot ready; ready never looks at in_valid[c]
    always_comb begin
        w_cand_data  = '0;
        w_cand_valid = 1'b0;
        w_ready      = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_cand == SELW'(k)) begin
                w_cand_data  = in_data[k*WIDTH +: WIDTH];
                w_cand_valid = in_valid[k];
                w_ready[k]   = w_cand_ok & w_load_en & rst_n;
            end
        end
    end

    assign in_ready = w_ready;
    assign w_xfer   = w_cand_ok & w_cand_valid & w_load_en & rst_n;

    // Single output stage: load on transfer, empty on an idle load slot, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_cand_data;
                r_out_id   <= w_cand;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule : mux_n1_stream
`default_nettype wire

// File: tb/tb_mux_n1_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_n1_stream
//  Description : Self-checking bench for mux_n1_stream. Three instances run in
//                lockstep: select mode NCH=4, round-robin NCH=4, select NCH=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n1_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_in;
    logic [3:0]  v_in;
    logic [1:0]  sel;
    logic        o_rdy;

    logic [3:0] rdy_a, rdy_b;
    logic [2:0] rdy_c;
    logic [7:0] od_a, od_b, od_c;
    logic       ov_a, ov_b, ov_c;
    logic [1:0] oid_a, oid_b, oid_c;

    always #5 clk = ~clk;

    mux_n1_stream #(.WIDTH(8), .NCH(4), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(d_in), .in_valid(v_in), .in_ready(rdy_a),
        .sel(sel), .out_data(od_a), .out_valid(ov_a), .out_ready(o_rdy), .out_id(oid_a));

    mux_n1_stream #(.WIDTH(8), .NCH(4), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(d_in), .in_valid(v_in), .in_ready(rdy_b),
        .sel(sel), .out_data(od_b), .out_valid(ov_b), .out_ready(o_rdy), .out_id(oid_b));

    mux_n1_stream #(.WIDTH(8), .NCH(3), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(d_in[23:0]), .in_valid(v_in[2:0]), .in_ready(rdy_c),
        .sel(sel), .out_data(od_c), .out_valid(ov_c), .out_ready(o_rdy), .out_id(oid_c));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model per instance: 0 = A, 1 = B, 2 = C
    int cfg_mode[3] = '{0, 1, 0};
    int cfg_nch[3]  = '{4, 4, 3};
    int mv[3], md[3], mid[3], mptr[3], exp_rdy[3];

    // Observed DUT values (kept as 4-state so X shows up as a miscompare)
    logic [31:0] obs_rdy[3], ov[3], od[3], oid[3];

    // One clock: drive inputs, sample ready before the edge, advance the model,
    // then sample the registered outputs just after the edge
    task automatic step(input logic [3:0] v, input logic [1:0] s, input logic [31:0] d,
                        input logic r, input logic rn);
        bit load, ok;
        int c, idx;
        v_in = v; sel = s; d_in = d; o_rdy = r; rst_n = rn;
        #1;
        obs_rdy[0] = 32'(rdy_a);
        obs_rdy[1] = 32'(rdy_b);
        obs_rdy[2] = 32'(rdy_c);
        for (int k = 0; k < 3; k++) begin
            load = (mv[k] == 0) || r;
            ok   = 1'b0;
            c    = 0;
            if (cfg_mode[k] == 1) begin
                for (int i = 0; i < cfg_nch[k]; i++) begin
                    idx = (mptr[k] + i) % cfg_nch[k];
                    if (!ok && v[idx]) begin
                        ok = 1'b1;
                        c  = idx;
                    end
                end
            end else begin
                c  = int'(s);
                ok = (c < cfg_nch[k]);
            end
            exp_rdy[k] = (rn && ok && load) ? (1 << c) : 0;
            if (!rn) begin
                mv[k] = 0; md[k] = 0; mid[k] = 0; mptr[k] = 0;
            end else if (load) begin
                if (ok && v[c]) begin
                    mv[k]  = 1;
                    md[k]  = int'(d[c*8 +: 8]);
                    mid[k] = c;
                    if (cfg_mode[k] == 1) mptr[k] = (c + 1) % cfg_nch[k];
                end else begin
                    mv[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        ov[0] = 32'(ov_a); od[0] = 32'(od_a); oid[0] = 32'(oid_a);
        ov[1] = 32'(ov_b); od[1] = 32'(od_b); oid[1] = 32'(oid_b);
        ov[2] = 32'(ov_c); od[2] = 32'(od_c); oid[2] = 32'(oid_c);
    endtask

    task automatic test_reset();
        step(4'hF, 2'd1, 32'h1234_5678, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_rdy[k] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_ready[%0d]: got %0h expected 0", k, obs_rdy[k]);
            end
            vectors++;
            if (ov[k] !== 32'd0 || od[k] !== 32'd0 || oid[k] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_out[%0d]: got v=%0h d=%0h id=%0h expected all 0", k, ov[k], od[k], oid[k]);
            end
        end
    endtask

    task automatic test_sel_basic();
        step(4'b0100, 2'd2, 32'h00A5_0000, 1'b1, 1'b1);
        vectors++;
        if (obs_rdy[0] !== 32'b0100) begin
            miscompares++;
            $display("FAIL sel_ready: got %0h expected 4", obs_rdy[0]);
        end
        vectors++;
        if (ov[0] !== 32'd1 || od[0] !== 32'hA5 || oid[0] !== 32'd2) begin
            miscompares++;
            $display("FAIL sel_capture: got v=%0h d=%0h id=%0h expected v=1 d=a5 id=2", ov[0], od[0], oid[0]);
        end
    endtask

    task automatic test_stall();
        logic [1:0] stall_sel[3] = '{2'd3, 2'd0, 2'd3};
        step(4'b0001, 2'd0, 32'h0000_003C, 1'b1, 1'b1);
        vectors++;
        if (ov[0] !== 32'd1 || od[0] !== 32'h3C) begin
            miscompares++;
            $display("FAIL stall_capture: got v=%0h d=%0h expected v=1 d=3c", ov[0], od[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step(4'hF, stall_sel[i], 32'hDEAD_BEEF, 1'b0, 1'b1);
            vectors++;
            if (obs_rdy[0] !== 32'd0) begin
                miscompares++;
                $display("FAIL stall_ready[%0d]: got %0h expected 0", i, obs_rdy[0]);
            end
            vectors++;
            if (ov[0] !== 32'd1 || od[0] !== 32'h3C || oid[0] !== 32'd0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%0h d=%0h id=%0h expected v=1 d=3c id=0", i, ov[0], od[0], oid[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int want_id[5] = '{0, 1, 2, 3, 0};
        step(4'h0, 2'd0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 2'd0, 32'h4433_2211, 1'b1, 1'b1);
            vectors++;
            if (obs_rdy[1] !== 32'(1 << want_id[i])) begin
                miscompares++;
                $display("FAIL rr_ready[%0d]: got %0h expected %0h", i, obs_rdy[1], 1 << want_id[i]);
            end
            vectors++;
            if (ov[1] !== 32'd1 || oid[1] !== 32'(want_id[i]) || od[1] !== 32'((want_id[i] + 1) * 8'h11)) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got v=%0h id=%0h d=%0h expected v=1 id=%0d d=%0h",
                         i, ov[1], oid[1], od[1], want_id[i], (want_id[i] + 1) * 8'h11);
            end
        end
    endtask

    task automatic test_rr_wrap();
        step(4'h0, 2'd0, 32'h0, 1'b1, 1'b0);
        step(4'b0100, 2'd0, 32'h4433_2211, 1'b1, 1'b1);
        step(4'b0010, 2'd0, 32'h4433_2211, 1'b1, 1'b1);
        vectors++;
        if (obs_rdy[1] !== 32'b0010 || oid[1] !== 32'd1 || ov[1] !== 32'd1) begin
            miscompares++;
            $display("FAIL rr_wrap: got rdy=%0h id=%0h v=%0h expected rdy=2 id=1 v=1", obs_rdy[1], oid[1], ov[1]);
        end
        step(4'hF, 2'd0, 32'h4433_2211, 1'b1, 1'b1);
        vectors++;
        if (oid[1] !== 32'd2 || od[1] !== 32'h33) begin
            miscompares++;
            $display("FAIL rr_next_ptr: got id=%0h d=%0h expected id=2 d=33", oid[1], od[1]);
        end
        step(4'h0, 2'd0, 32'h4433_2211, 1'b1, 1'b1);
        vectors++;
        if (obs_rdy[1] !== 32'd0 || ov[1] !== 32'd0) begin
            miscompares++;
            $display("FAIL rr_idle: got rdy=%0h v=%0h expected rdy=0 v=0", obs_rdy[1], ov[1]);
        end
    endtask

    task automatic test_bad_sel();
        for (int i = 0; i < 2; i++) begin
            step(4'b0111, 2'd3, 32'h00CC_BBAA, 1'b1, 1'b1);
            vectors++;
            if (obs_rdy[2] !== 32'd0 || ov[2] !== 32'd0) begin
                miscompares++;
                $display("FAIL bad_sel[%0d]: got rdy=%0h v=%0h expected rdy=0 v=0", i, obs_rdy[2], ov[2]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step(4'hF, 2'd1, 32'h4433_2211, 1'b1, 1'b1);
        step(4'hF, 2'd1, 32'h4433_2211, 1'b0, 1'b1);
        vectors++;
        if (ov[1] !== 32'd1) begin
            miscompares++;
            $display("FAIL mid_stall_held: got v=%0h expected 1", ov[1]);
        end
        step(4'hF, 2'd1, 32'h4433_2211, 1'b0, 1'b0);
        vectors++;
        if (ov[1] !== 32'd0 || od[1] !== 32'd0 || oid[1] !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_stall_reset: got v=%0h d=%0h id=%0h expected all 0", ov[1], od[1], oid[1]);
        end
        step(4'hF, 2'd1, 32'h4433_2211, 1'b1, 1'b1);
        vectors++;
        if (ov[1] !== 32'd1 || oid[1] !== 32'd0 || od[1] !== 32'h11) begin
            miscompares++;
            $display("FAIL mid_stall_restart: got v=%0h id=%0h d=%0h expected v=1 id=0 d=11", ov[1], oid[1], od[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) != 0));
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_rdy[k] !== 32'(exp_rdy[k])) begin
                    miscompares++;
                    $display("FAIL rand_ready[%0d] cyc %0d: got %0h expected %0h", k, n, obs_rdy[k], exp_rdy[k]);
                end
                vectors++;
                if (ov[k] !== 32'(mv[k])) begin
                    miscompares++;
                    $display("FAIL rand_valid[%0d] cyc %0d: got %0h expected %0h", k, n, ov[k], mv[k]);
                end
                if (mv[k] != 0) begin
                    vectors++;
                    if (od[k] !== 32'(md[k]) || oid[k] !== 32'(mid[k])) begin
                        miscompares++;
                        $display("FAIL rand_word[%0d] cyc %0d: got d=%0h id=%0h expected d=%0h id=%0h",
                                 k, n, od[k], oid[k], md[k], mid[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; d_in = '0; v_in = '0; sel = '0; o_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0; md[k] = 0; mid[k] = 0; mptr[k] = 0; exp_rdy[k] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_sel_basic();
        test_stall();
        test_back_to_back();
        test_rr_wrap();
        test_bad_sel();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_n1_stream
`default_nettype wire

// File: doc/mux_n1_stream.md
MUX_N1_STREAM -- requirements
Module: mux_n1_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per data channel (1..64).
REQ-002 SHALL have parameter NCH, default 4: number of input channels (2..16).
REQ-003 SHALL have parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 SHALL define local constant SELW = max(1, ceil(log2(NCH))).
REQ-005 SHALL have one clock and a synchronous, active-low reset. Ports are listed below as name, direction, width and meaning, clock and reset first.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel data valid.
REQ-010 in_ready  output  NCH  per-channel accept.
REQ-011 sel  input  SELW  channel select; used only in MODE 0.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_id  output  SELW  channel index of the word held in out_data.

Function
REQ-016 SHALL define load_en = !out_valid | out_ready; the output register accepts a word only when load_en=1.
REQ-017 SHALL determine the candidate channel c as follows: in MODE 0, c = sel; in MODE 1, c = the first k with in_valid[k]=1, scanning from ptr upward modulo NCH.
REQ-018 SHALL drive in_ready[c] = load_en, and all other in_ready bits = 0. in_ready SHALL NOT depend on in_valid[c], so there is no combinational valid-to-ready loop.
REQ-019 A transfer SHALL occur when in_valid[c] & in_ready[c]; on that edge out_data <= in_data[c], out_id <= c and out_valid <= 1 (latency of 1 cycle).
REQ-020 When load_en=1 and no transfer occurs, out_valid SHALL be 0 on the next cycle.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_id and out_valid SHALL hold stable.
REQ-022 With out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles.
REQ-023 In MODE 1, after each transfer ptr SHALL be set to (c+1) mod NCH; otherwise ptr holds.
REQ-024 In MODE 1 with no in_valid bit set, no in_ready bit SHALL be asserted.
REQ-025 In MODE 0 with sel >= NCH (non-power-of-2 NCH), all in_ready bits SHALL be 0 and no transfer SHALL occur.
REQ-026 A change of sel while a word is held SHALL NOT affect out_data or out_id.
REQ-027 The channel index arithmetic SHALL wrap from NCH-1 to 0 and SHALL NOT produce an index >= NCH.

Reset
REQ-028 When rst_n=0 at a rising edge: out_valid=0, out_data=0, out_id=0, ptr=0.
REQ-029 While rst_n=0, in_ready SHALL be all 0.
REQ-030 Assertion of reset while a word is held SHALL discard that word; no partial transfer SHALL be reported.

Structure
REQ-031 Package mux_pkg SHALL hold the MODE_SEL=0 and MODE_RR=1 constants and a clog2 helper function.
REQ-032 The round-robin candidate search SHALL be a sub-module rr_pick (inputs: req[NCH] and ptr; outputs: grant index and any_req); it is instantiated only when MODE=1.
REQ-033 The output register SHALL be the block's only datapath storage; no FIFO beyond the single register.

Verification
REQ-034 MODE 0, NCH=4, WIDTH=8: sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=8'hA5, out_id=2, out_valid=1; in_ready=4'b0100.
REQ-035 Stall: hold out_ready=0 for 3 cycles after the capture of 8'h3C -> out_data stays 8'h3C and in_ready stays 0; sel is toggled 0->3 during the stall with no effect on the held word.
REQ-036 MODE 1: in_valid=4'b1111 constant, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-037 MODE 1: ptr=3, in_valid=4'b0010 -> channel 1 granted, wrapping past channel 3 to 0 then 1; the next ptr=2.
REQ-038 NCH=3, MODE 0, sel=3 with in_valid=3'b111 -> in_ready=0 and out_valid stays 0.
REQ-039 Reset mid-stall: out_valid=1 and rst_n=0 for 1 cycle -> out_valid=0, out_data=0, out_id=0, and round-robin restarts at channel 0.
